// File: rtl/prio_arb_n.sv
// prio_arb_n: registered N-input priority arbiter. It supports fixed-priority
// mode (the highest index wins) and round-robin mode. A grant is held stable
// until the consumer acknowledges it, and the acknowledging edge issues the
// next grant in the same cycle.

// Per-lane qualifier: this requester sits strictly above the round-robin pointer.
module prio_arb_n_lane #(
  parameter int W = 3,
  parameter int K = 0
) (
  input  logic         req,
  input  logic [W-1:0] ptr,
  output logic         above
);
  localparam logic [W-1:0] IDX = W'(K);

  // A pending request ahead of the pointer gets first pick in round-robin.
  assign above = req & (IDX > ptr);
endmodule

module prio_arb_n #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         ack,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot
);
  localparam logic [0:0]   IDLE   = 1'b0;
  localparam logic [0:0]   GRANT  = 1'b1;
  localparam logic [W-1:0] PTR_RST = W'(N - 1);

  logic [0:0]   state;
  logic [W-1:0] ptr;
  logic [N-1:0] above;
  logic         arb_evt;
  logic [W-1:0] fix_idx, rr_up_idx, rr_lo_idx, rr_idx, win_idx;
  logic         rr_up_hit;
  logic [N-1:0] win_oh;

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_lane
      prio_arb_n_lane #(.W(W), .K(k)) u_lane (
        .req   (req[k]),
        .ptr   (ptr),
        .above (above[k])
      );
    end
  endgenerate

  // A decision is taken whenever nothing is held or the held grant is consumed.
  assign arb_evt   = (state == IDLE) | ack;
  assign gnt_valid = (state == GRANT);

  // Winner selection. Fixed mode picks the highest set bit. Round-robin mode
  // picks the lowest set bit above ptr. If no such bit exists, it wraps to the
  // lowest set bit overall, so the search is modulo N and never reaches 2^W.
  always_comb begin
    fix_idx   = '0;
    rr_up_idx = '0;
    rr_lo_idx = '0;
    rr_up_hit = 1'b0;
    for (int i = 0; i < N; i++)
      if (req[i]) fix_idx = W'(i);
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) rr_lo_idx = W'(i);
      if (above[i]) begin
        rr_up_idx = W'(i);
        rr_up_hit = 1'b1;
      end
    end
    rr_idx  = rr_up_hit ? rr_up_idx : rr_lo_idx;
    win_idx = mode ? rr_idx : fix_idx;
    win_oh  = '0;
    for (int i = 0; i < N; i++)
      win_oh[i] = (win_idx == W'(i));
  end

  // Grant register and pointer. These update only at arbitration events, so
  // req and mode are ignored while a grant is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      ptr        <= PTR_RST;
    end else if (arb_evt) begin
      if (|req) begin
        state      <= GRANT;
        gnt_idx    <= win_idx;
        gnt_onehot <= win_oh;
        ptr        <= win_idx;
      end else begin
        state      <= IDLE;
        gnt_idx    <= '0;
        gnt_onehot <= '0;
      end
    end
  end
endmodule

// File: tb/tb_prio_arb_n.sv
// tb_prio_arb_n: scoreboard bench for prio_arb_n. It drives an N=8 instance and
// an N=5 instance side by side. A behavioural model predicts each edge's
// outcome, the prediction is queued, and it is checked one step after the edge.
module tb_prio_arb_n;
  typedef struct packed {
    logic       v;
    logic [2:0] ix;
    logic [7:0] oh;
  } exp_t;

  logic       clk, rst_n;
  logic [7:0] req8;
  logic [4:0] req5;
  logic       mode8, ack8, mode5, ack5;
  logic       v8, v5;
  logic [2:0] ix8, ix5;
  logic [7:0] oh8;
  logic [4:0] oh5;

  int n_vec = 0;
  int n_err = 0;

  exp_t q8[$];
  exp_t q5[$];

  // Model state for each instance.
  logic       mv8, mv5;
  logic [2:0] mix8, mix5, mp8, mp5;

  prio_arb_n #(.N(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .req(req8), .mode(mode8), .ack(ack8),
    .gnt_valid(v8), .gnt_idx(ix8), .gnt_onehot(oh8)
  );

  prio_arb_n #(.N(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .req(req5), .mode(mode5), .ack(ack5),
    .gnt_valid(v5), .gnt_idx(ix5), .gnt_onehot(oh5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour. The search is written as a rotating scan starting at
  // ptr+1 modulo n.
  function automatic void model(input int n, input logic [7:0] r, input logic md,
                                input logic ak, inout logic v, inout logic [2:0] ix,
                                inout logic [2:0] p);
    int j;
    if (v && !ak) return;
    if (r == 8'd0) begin
      v  = 1'b0;
      ix = 3'd0;
      return;
    end
    if (!md) begin
      for (int i = n - 1; i >= 0; i--)
        if (r[i]) begin ix = 3'(i); break; end
    end else begin
      for (int i = 1; i <= n; i++) begin
        j = (int'(p) + i) % n;
        if (r[j]) begin ix = 3'(j); break; end
      end
    end
    v = 1'b1;
    p = ix;
  endfunction

  function automatic exp_t mk(input logic v, input logic [2:0] ix);
    exp_t e;
    e.v  = v;
    e.ix = ix;
    e.oh = v ? (8'd1 << ix) : 8'd0;
    return e;
  endfunction

  task automatic model_reset();
    mv8 = 1'b0; mix8 = 3'd0; mp8 = 3'd7;
    mv5 = 1'b0; mix5 = 3'd0; mp5 = 3'd4;
  endtask

  // Apply the current inputs across one rising edge and check both instances.
  task automatic cyc();
    exp_t e;
    model(8, req8, mode8, ack8, mv8, mix8, mp8);
    q8.push_back(mk(mv8, mix8));
    model(5, {3'b000, req5}, mode5, ack5, mv5, mix5, mp5);
    q5.push_back(mk(mv5, mix5));
    @(posedge clk);
    #1;
    if (q8.size() == 0) chk("q8_empty", 32'd1, 32'd0);
    else begin
      e = q8.pop_front();
      chk("v8", 32'(v8), 32'(e.v));
      chk("ix8", 32'(ix8), 32'(e.ix));
      chk("oh8", 32'(oh8), 32'(e.oh));
    end
    if (q5.size() == 0) chk("q5_empty", 32'd1, 32'd0);
    else begin
      e = q5.pop_front();
      chk("v5", 32'(v5), 32'(e.v));
      chk("ix5", 32'(ix5), 32'(e.ix));
      chk("oh5", 32'(oh5), 32'(e.oh[4:0]));
    end
  endtask

  task automatic drv8(input logic [7:0] r, input logic md, input logic ak);
    req8 = r; mode8 = md; ack8 = ak;
  endtask

  initial begin
    rst_n = 1'b0;
    req8 = '0; mode8 = 1'b0; ack8 = 1'b0;
    req5 = '0; mode5 = 1'b0; ack5 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v", 32'(v8), 32'd0);
    chk("rst_ix", 32'(ix8), 32'd0);
    chk("rst_oh", 32'(oh8), 32'd0);
    rst_n = 1'b1;

    // Fixed-priority pick, then hold the grant without ack.
    drv8(8'b0010_0110, 1'b0, 1'b0);
    cyc();
    chk("fix_ix", 32'(ix8), 32'd5);
    chk("fix_oh", 32'(oh8), 32'h20);
    for (int i = 0; i < 5; i++) begin
      drv8(8'(i * 37 + 1), 1'b1, 1'b0);
      cyc();
    end
    chk("hold_ix", 32'(ix8), 32'd5);

    // Sticky grant: reach idx 3, then drop req[3] and flip mode to round-robin.
    drv8(8'b0000_1000, 1'b0, 1'b1); cyc();
    chk("stk_ix", 32'(ix8), 32'd3);
    drv8(8'b0000_0000, 1'b1, 1'b0); cyc(); cyc();
    chk("stk_hold", 32'(ix8), 32'd3);
    drv8(8'b1000_0001, 1'b1, 1'b1); cyc();
    chk("stk_rr7", 32'(ix8), 32'd7);
    drv8(8'b0000_0011, 1'b1, 1'b1); cyc();
    chk("stk_rr0", 32'(ix8), 32'd0);
    // Same scenario with the mode flipped toward fixed priority.
    drv8(8'b0000_1000, 1'b1, 1'b1); cyc();
    chk("stk2_ix", 32'(ix8), 32'd3);
    drv8(8'b0000_0000, 1'b0, 1'b0); cyc();
    drv8(8'b1000_0001, 1'b0, 1'b1); cyc();
    chk("stk_fix7", 32'(ix8), 32'd7);

    // Empty retirement, ack pulses while idle, then ack in idle with a request.
    drv8(8'b0000_0000, 1'b0, 1'b1); cyc();
    chk("empty_v", 32'(v8), 32'd0);
    chk("empty_ix", 32'(ix8), 32'd0);
    chk("empty_oh", 32'(oh8), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drv8(8'b0000_0000, 1'(i), 1'(i + 1)); cyc();
    end
    drv8(8'b0000_0100, 1'b0, 1'b1); cyc();
    chk("idle_ack_ix", 32'(ix8), 32'd2);

    // Asynchronous reset between edges while a grant is held.
    drv8(8'b0100_0000, 1'b0, 1'b1); cyc();
    chk("pre_rst_v", 32'(v8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_v", 32'(v8), 32'd0);
    chk("arst_ix", 32'(ix8), 32'd0);
    chk("arst_oh", 32'(oh8), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin rotation with no bubbles on N=8, and the modulo-5 wrap on N=5.
    drv8(8'hFF, 1'b1, 1'b1);
    req5 = 5'b10001; mode5 = 1'b1; ack5 = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cyc();
      chk("rr_seq", 32'(ix8), 32'(i % 8));
      chk("rr5_seq", 32'(ix5), (i % 2 == 0) ? 32'd0 : 32'd4);
    end

    // Random traffic on both instances.
    for (int i = 0; i < 200; i++) begin
      drv8(8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      req5  = 5'($urandom);
      mode5 = 1'($urandom);
      ack5  = 1'($urandom_range(0, 3) != 0);
      cyc();
      if (v5) chk("idx5_range", 32'(ix5 <= 3'd4), 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/prio_arb_n.md
# prio_arb_n

Parametrised, registered N-input priority arbiter, the sequential successor to the combinational priority encoders in this library. Each arbitration encodes the winning request into a binary index plus a valid flag, as the encoders do. It adds a selectable round-robin mode and a grant/acknowledge handshake that holds the grant stable until it is consumed. It sits between several requesters and a single shared resource.

## Interface
- `N`, default 8: number of request lines. Legal range is N >= 2; N need not be a power of two.
- `W`, default $clog2(N): index width. Derived; must not be overridden.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input N: request vector; bit k = requester k.
- `mode` input 1: 0 = fixed priority (highest index wins); 1 = round-robin.
- `ack` input 1: consumer accepts the current grant. Ignored while `gnt_valid`=0.
- `gnt_valid` output 1: a grant is held.
- `gnt_idx` output W: binary index of the granted requester.
- `gnt_onehot` output N: one-hot form of `gnt_idx`. All zeros when `gnt_valid`=0.

## Operation
- Two states:
  - IDLE: `gnt_valid`=0.
  - GRANT: `gnt_valid`=1; `gnt_idx` and `gnt_onehot` are frozen.
- An arbitration event occurs on any rising edge where:
  - the state is IDLE, or
  - the state is GRANT and `ack`=1.
- At an arbitration event:
  - if `req` != 0, compute the winner, register it, and go to (or stay in) GRANT;
  - if `req` == 0, go to IDLE, and clear `gnt_idx` and `gnt_onehot` to 0.
- Fixed priority (`mode`=0): the winner is the highest set bit of `req`. This is the same ordering as the existing encoders: i[N-1] > … > i[0].
- Round-robin (`mode`=1):
  - Search starts at index `ptr`+1 and increases, wrapping from N-1 to 0.
  - The first set bit found wins.
  - `ptr` is internal, W bits wide, and always in 0..N-1.
  - `ptr` is loaded with the winner index at every arbitration event that produces a grant, in both modes.
- `mode` and `req` are sampled only at arbitration events. Changing either while in GRANT has no effect until the next event.
- The grant is sticky: if the granted requester drops `req` while in GRANT, the grant is still held until `ack`.
- With `ack`=1 and requests pending, the edge that retires one grant issues the next. Back-to-back grants therefore have no bubble cycle.
- With `ack`=1 while in IDLE, the machine behaves exactly as IDLE with `ack`=0.
- Width and wrap rules for non-power-of-two N:
  - indices N..2^W-1 are never produced;
  - the round-robin wrap is modulo N, not modulo 2^W.
- Reset (`rst_n`=0, asynchronous, effective immediately, also mid-grant):
  - state = IDLE;
  - `gnt_valid`=0, `gnt_idx`=0, `gnt_onehot`=0;
  - `ptr`=N-1, so the first round-robin search after reset starts at index 0.
- After `rst_n` deasserts, the first arbitration event is the first rising edge at which `rst_n` is high.

## Timing
- Latency: `req` asserted before rising edge k, in IDLE, gives `gnt_valid`=1 with the correct index from edge k onward (visible in cycle k+1).
- Retirement: a grant whose `ack` is sampled high at edge k is replaced or removed at edge k. This gives one grant per cycle maximum.
- All outputs are registered; there is no combinational path from `req`, `mode` or `ack` to any output.
- `gnt_onehot` == (1 << `gnt_idx`) whenever `gnt_valid`=1.

## Test plan
- **Reset and fixed-priority pick.** Reset; then `mode`=0, `req`=8'b0010_0110.
  - One edge later: `gnt_valid`=1, `gnt_idx`=5, `gnt_onehot`=8'b0010_0000.
  - Hold `ack`=0 for 5 cycles: the grant is unchanged.
- **Round-robin rotation.** `mode`=1, `req`=8'hFF constant, `ack`=1 continuously from reset release.
  - Grants on consecutive edges: 0,1,2,…,7,0 with no bubbles.
- **Sticky grant and mode sampling.**
  - In GRANT idx=3, drop `req`[3] and flip `mode`: the grant stays at 3.
  - On `ack` with `req`=8'b1000_0001: the new winner follows the new mode (rr: ptr=3 → idx 7; fixed: idx 7). Then `req`=8'b0000_0011, rr: next idx is 0.
- **Empty retirement.** In GRANT, `ack`=1 with `req`=0.
  - Next cycle: `gnt_valid`=0, `gnt_idx`=0, `gnt_onehot`=0.
  - `ack` pulses while IDLE do nothing.
- **Non-power-of-two wrap.** N=5, `mode`=1, `req`=5'b10001, `ack`=1.
  - Grants alternate 0,4,0,4; the index never exceeds 4.
- **Asynchronous reset mid-grant.** Assert `rst_n`=0 between clock edges while `gnt_valid`=1.
  - Outputs clear immediately without a clock edge.
  - After release with `mode`=1, `req`=8'hFF: the first grant is 0.
